// File: rtl/ring_pkg.sv
// ring_pkg: shared monitor state type and the ring direction / position helpers
package ring_pkg;
    localparam int MAX_N = 64;
    localparam int MAX_W = $clog2(MAX_N);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
    function automatic logic [MAX_N-1:0] ring_rotate(input logic [MAX_N-1:0] q, input int n);
        return ((q << 1) | (q >> (n - 1))) & ((MAX_N'(1) << n) - MAX_N'(1));
    endfunction
    function automatic logic [MAX_W-1:0] onehot_idx(input logic [MAX_N-1:0] q);
        onehot_idx = '0;
        for (int i = 0; i < MAX_N; i++)
            if (q[i]) onehot_idx = MAX_W'(i);
    endfunction
endpackage

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc: one-hot validity check and binary position of the hot bit
module ring_onehot_enc
    import ring_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     ring_q,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    assign valid = $countones(ring_q) == 1;
    assign idx = IDX_W'(onehot_idx(MAX_N'(ring_q)));
endmodule

// File: rtl/ring_monitor.sv
// ring_monitor: checks a one-hot ring token advances one step per sample, tracks lock and errors
module ring_monitor
    import ring_pkg::*;
#(
    parameter int N = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     ring_q,
    input  logic             sample_en,
    input  logic             err_clr,
    output logic [IDX_W-1:0] index,
    output logic             onehot_ok,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count
);
    localparam int GW = LOCK_CNT > 1 ? $clog2(LOCK_CNT) : 1;
    state_t state, state_nx;
    logic [GW-1:0] good_cnt, cnt_nx;
    logic [N-1:0] prev_q, expected;
    logic [IDX_W-1:0] idx;
    logic valid, step_ok, err_nx, wrap_nx;
    ring_onehot_enc #(.N(N)) u_enc (.ring_q(ring_q), .valid(valid), .idx(idx));
    assign expected = N'(ring_rotate(MAX_N'(prev_q), N));
    assign step_ok = valid && ring_q == expected;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNLOCKED;
            good_cnt <= '0;
        end else begin
            state <= state_nx;
            good_cnt <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx = good_cnt;
        if (sample_en)
            case (state)
                UNLOCKED: if (valid) begin
                    state_nx = ACQUIRE;
                    cnt_nx = '0;
                end
                ACQUIRE: if (step_ok && good_cnt == GW'(LOCK_CNT - 1)) state_nx = LOCKED;
                else if (step_ok) cnt_nx = good_cnt + 1'b1;
                else begin
                    state_nx = valid ? ACQUIRE : UNLOCKED;
                    cnt_nx = '0;
                end
                LOCKED: if (!step_ok) begin
                    state_nx = valid ? ACQUIRE : UNLOCKED;
                    cnt_nx = '0;
                end
                default: state_nx = UNLOCKED;
            endcase
    end
    always_comb begin
        err_nx = sample_en && state == LOCKED && !step_ok;
        wrap_nx = sample_en && state == LOCKED && step_ok && ring_q[0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            index <= '0;
            onehot_ok <= 1'b0;
            locked <= 1'b0;
            err_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err_nx;
            wrap_pulse <= wrap_nx;
            locked <= state_nx == LOCKED;
            if (sample_en) begin
                prev_q <= ring_q;
                onehot_ok <= valid;
                if (valid) index <= idx;
            end
            if (err_clr) err_count <= '0;
            else if (err_nx && err_count != '1) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: directed plan plus randomized traffic against a position-based reference model
module tb_ring_monitor;
    localparam int N = 4;
    localparam int LK = 2;
    logic clk = 1'b0;
    logic reset, sample_en, err_clr;
    logic [N-1:0] ring_q;
    logic [1:0] index, index_b;
    logic onehot_ok, locked, err_pulse, wrap_pulse;
    logic onehot_ok_b, locked_b, err_pulse_b, wrap_pulse_b;
    logic [7:0] err_count;
    logic [1:0] err_count_b;
    int compared = 0, mismatched = 0;
    int m_idx, m_ok, m_lk, m_err, m_wrap, m_c8, m_c2, anchor, run, prev_v, prev_pos;
    bit trans;
    logic [N-1:0] cur;

    ring_monitor #(.N(N), .LOCK_CNT(LK), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ring_q(ring_q), .sample_en(sample_en), .err_clr(err_clr),
        .index(index), .onehot_ok(onehot_ok), .locked(locked), .err_pulse(err_pulse),
        .wrap_pulse(wrap_pulse), .err_count(err_count));
    ring_monitor #(.N(N), .LOCK_CNT(LK), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .ring_q(ring_q), .sample_en(sample_en), .err_clr(err_clr),
        .index(index_b), .onehot_ok(onehot_ok_b), .locked(locked_b), .err_pulse(err_pulse_b),
        .wrap_pulse(wrap_pulse_b), .err_count(err_count_b));

    always #5 clk = ~clk;

    function automatic int pop(input logic [N-1:0] q);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(q[i]);
        return c;
    endfunction
    function automatic int posf(input logic [N-1:0] q);
        int p = 0;
        for (int i = 0; i < N; i++) if (q[i]) p = i;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lock = LK consecutive correct advances counted from a valid anchor sample
    task automatic model(input logic [N-1:0] q, input bit en, input bit clr, input bit rst);
        int v, p, ok, was;
        trans = 0;
        if (rst) begin
            {m_idx, m_ok, m_lk, m_err, m_wrap, m_c8, m_c2, anchor, run, prev_v, prev_pos} = '0;
            return;
        end
        v = int'(pop(q) == 1);
        p = posf(q);
        ok = int'(v && prev_v && p == (prev_pos + 1) % N);
        m_err = int'(en && m_lk && !ok);
        m_wrap = int'(en && m_lk && ok && p == 0);
        was = m_lk;
        if (en) begin
            if (m_lk) begin
                if (!ok) begin m_lk = 0; anchor = v; run = 0; end
            end else if (anchor) begin
                if (ok) begin run++; if (run == LK) m_lk = 1; end
                else if (v) run = 0;
                else anchor = 0;
            end else if (v) begin anchor = 1; run = 0; end
            m_ok = v;
            if (v) m_idx = p;
            prev_v = v;
            prev_pos = p;
        end
        trans = !was && m_lk && p == 0;
        if (clr) begin m_c8 = 0; m_c2 = 0; end
        else if (m_err) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3) m_c2++;
        end
    endtask

    task automatic step(input logic [N-1:0] q, input bit en, input bit clr, input bit rst);
        ring_q = q; sample_en = en; err_clr = clr; reset = rst;
        @(posedge clk); #1;
        model(q, en, clr, rst);
        check("index", 32'(index), 32'(m_idx));
        check("onehot_ok", 32'(onehot_ok), 32'(m_ok));
        check("locked", 32'(locked), 32'(m_lk));
        check("err_pulse", 32'(err_pulse), 32'(m_err));
        if (!trans) check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
        check("err_count", 32'(err_count), 32'(m_c8));
        check("err_count_sat", 32'(err_count_b), 32'(m_c2));
    endtask

    task automatic adv(input int k);
        for (int i = 0; i < k; i++) begin
            cur = {cur[N-2:0], cur[N-1]};
            step(cur, 1, 0, 0);
        end
    endtask

    initial begin
        int r;
        logic [N-1:0] q;
        ring_q = '0; sample_en = 0; err_clr = 0; reset = 1;
        @(negedge clk);
        repeat (3) step(4'b0000, 1, 1, 1);
        step(4'b0001, 1, 0, 0); step(4'b0010, 1, 0, 0); step(4'b0100, 1, 0, 0);
        check("plan1_locked", 32'(locked), 32'd1);
        step(4'b1000, 1, 0, 0); step(4'b0001, 1, 0, 0);
        check("plan1_wrap", 32'(wrap_pulse), 32'd1);
        check("plan1_index", 32'(index), 32'd0);
        step(4'b0000, 1, 0, 1);
        repeat (10) step(4'b0000, 1, 0, 0);
        step(4'b0000, 1, 0, 1);
        cur = 4'b1000; adv(6);
        step(4'b0110, 1, 0, 0);
        check("plan3_err", 32'(err_pulse), 32'd1);
        check("plan3_index_hold", 32'(index), 32'd1);
        step(4'b0000, 1, 0, 1);
        cur = 4'b0001; adv(4);
        step(4'b0100, 1, 0, 0);
        step(4'b1000, 1, 0, 0); step(4'b0001, 1, 0, 0);
        check("plan4_relock", 32'(locked), 32'd1);
        check("plan4_count", 32'(err_count), 32'd1);
        step(4'b0000, 1, 0, 1);
        cur = 4'b0001; step(cur, 1, 0, 0);
        for (int e = 0; e < 5; e++) begin
            adv(LK);
            step(cur, 1, 0, 0);
        end
        check("plan5_sat", 32'(err_count_b), 32'd3);
        adv(LK);
        step(cur, 1, 1, 0);
        check("plan5_clr", 32'(err_count_b), 32'd0);
        for (int i = 0; i < 5; i++) step(4'(1 << (i % N)), 0, 0, 0);
        adv(LK); step(cur, 1, 0, 0); adv(LK); step(cur, 1, 0, 0);
        adv(LK);
        step(cur, 1, 0, 1);
        adv(1);
        check("plan6_unlocked", 32'(locked), 32'd0);
        adv(LK);
        cur = 4'b0001;
        repeat (3000) begin
            r = $urandom_range(99);
            q = r < 70 ? {cur[N-2:0], cur[N-1]} :
                r < 78 ? cur :
                r < 85 ? {cur[N-3:0], cur[N-1:N-2]} : 4'($urandom);
            if (pop(q) == 1) cur = q;
            step(q, $urandom_range(9) != 0, $urandom_range(49) == 0, $urandom_range(199) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Receive-side checker for the one-hot ring counter token.
- Samples an N-bit ring state each enabled cycle and verifies it is exactly one-hot and advanced by one position in the ring direction (q[0] to q[1] to ... to q[N-1] to q[0]).
- Encodes the token position to a binary index, reports lock status, flags errors and wrap-around, and keeps a saturating error count.
- Sits beside any ring counter instance as its consumer and integrity monitor.

Parameters:
- N, 4, ring width (number of flip-flops in the monitored ring), N >= 2.
- LOCK_CNT, 2, consecutive correct advances required to enter LOCKED, >= 1.
- CNT_W, 8, width of the saturating error counter.
- IDX_W, $clog2(N), derived localparam for the index width; not overridable.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ring_q  in  N  monitored ring state.
- sample_en  in  1  sample/advance qualifier; when low, all state holds.
- err_clr  in  1  synchronous clear of err_count.
- index  out  IDX_W  binary position of the hot bit.
- onehot_ok  out  1  last sample had exactly one bit set.
- locked  out  1  high in LOCKED state.
- err_pulse  out  1  one-cycle pulse on a step error while LOCKED.
- wrap_pulse  out  1  one-cycle pulse when the token re-enters bit 0 while LOCKED.
- err_count  out  CNT_W  saturating count of err_pulse events.

Behaviour:
- Reset (reset=1 at posedge) overrides sample_en and err_clr and sets:
  - state=UNLOCKED, prev_q=0, good_cnt=0;
  - index=0, onehot_ok=0, locked=0, err_pulse=0, wrap_pulse=0, err_count=0.
- Reset mid-operation gives the identical result at the next edge.
- All outputs are registered. Latency is 1 cycle from a ring_q sample to the outputs reflecting it.
- Combinational terms:
  - valid = popcount(ring_q)==1.
  - expected = rotate-left-by-1(prev_q), i.e. expected[0]=prev_q[N-1] and expected[i]=prev_q[i-1].
  - step_ok = valid && ring_q==expected.
- On every enabled edge (sample_en=1):
  - prev_q <= ring_q.
  - onehot_ok <= valid.
  - index <= position of the hot bit if valid, else index holds.
- sample_en=0: prev_q, state, good_cnt, index, onehot_ok and err_count hold; err_pulse and wrap_pulse are 0.
- FSM, evaluated only when sample_en=1:
  - UNLOCKED: if valid, go to ACQUIRE with good_cnt=0; else stay.
  - ACQUIRE:
    - step_ok and good_cnt==LOCK_CNT-1: go to LOCKED.
    - step_ok otherwise: good_cnt+1.
    - not step_ok and valid: stay in ACQUIRE, good_cnt=0.
    - not valid: go to UNLOCKED.
  - LOCKED:
    - step_ok: stay; wrap_pulse=1 if ring_q[0]==1.
    - otherwise: err_pulse=1, then ACQUIRE with good_cnt=0 if valid, else UNLOCKED.
- A held token (ring_q==prev_q with sample_en=1) is a step error.
- All-zero and multi-hot values are invalid and never lock.
- locked=1 exactly when state==LOCKED, registered with the state.
- err_count:
  - increments on each err_pulse and saturates at 2^CNT_W-1.
  - err_clr clears it to 0; err_clr wins over a simultaneous increment.
  - err_clr works regardless of sample_en.
- No wrap_pulse is raised outside LOCKED; the ACQUIRE-to-LOCKED transition edge may raise wrap_pulse if ring_q[0]==1.

Decomposition:
- Shared package ring_pkg:
  - state enum {UNLOCKED, ACQUIRE, LOCKED};
  - function ring_rotate(q) for the expected-next rule;
  - function onehot_idx(q).
- Ring generator and monitor both use ring_rotate so the direction rule is defined once.
- One sub-module is natural: ring_onehot_enc, a combinational block taking ring_q and giving valid and idx.
- The FSM, counters and output registers stay in ring_monitor.

Test Plan:
1. N=4, LOCK_CNT=2. Hold reset 3 cycles, then drive ring_q 0001,0010,0100,1000,0001 one per cycle with sample_en=1 -> index 0,1,2,3,0; locked=1 after the sample of 0100; wrap_pulse=1 only for the 1000 to 0001 step; err_count=0.
2. ring_q=0000 for 10 cycles after reset -> onehot_ok=0, locked=0, err_pulse never set, index=0.
3. While locked at 0010, drive 0110 -> next edge: err_pulse=1 for one cycle, err_count=1, locked=0, state UNLOCKED, index holds 1.
4. While locked at 0001, drive 0100 (skip) -> err_pulse, state ACQUIRE; then 1000,0001 -> locked=1 again; err_count=1.
5. With CNT_W=2, force 5 step errors -> err_count saturates at 3. Assert err_clr in the same cycle as a 6th error -> err_count=0. sample_en=0 for 5 cycles with ring_q changing -> no output change, no pulses.
6. Assert reset one cycle while locked with err_count=2 -> next edge: all outputs 0 and state UNLOCKED; relock requires a full ACQUIRE sequence.
